// File: rtl/seq_divider_8by4.sv
// Sequential 8-by-4 unsigned restoring divider: one quotient bit per clock, MSB first.
// A zero divisor skips the iteration and reports all-ones quotient/remainder with dbz set.
module seq_divider_8by4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       dbz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [7:0] dvd_q;
    logic [3:0] dsr_q;
    logic [4:0] prem;
    logic [3:0] cnt;
    logic       zdiv;
    logic       accept;
    logic       last_iter;
    logic [5:0] stp;

    // One restoring step: {quotient bit, next partial remainder}.
    function automatic logic [5:0] div_step(input logic [4:0] pr,
                                            input logic       bitin,
                                            input logic [3:0] d);
        logic [5:0] sh;
        logic       qb;
        logic [4:0] nr;
        sh = {pr, bitin};
        qb = (sh >= {2'b00, d});
        nr = qb ? (sh[4:0] - {1'b0, d}) : sh[4:0];
        return {qb, nr};
    endfunction

    // The cycle carrying a done pulse is not an accepting cycle, which is
    // what spaces back-to-back zero-divisor requests three cycles apart.
    assign accept    = (state == IDLE) && start && !done;
    assign last_iter = (cnt == 4'd1);
    assign stp       = div_step(prem, dvd_q[7], dsr_q);
    assign busy      = (state == CALC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (divisor != 4'd0) ? CALC : DONE;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // dvd_q doubles as the quotient collector: dividend bits shift out the
    // top while quotient bits shift in at the bottom.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q     <= 8'h00;
            dsr_q     <= 4'h0;
            prem      <= 5'h00;
            cnt       <= 4'h0;
            zdiv      <= 1'b0;
            quotient  <= 8'h00;
            remainder <= 4'h0;
            dbz       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvd_q <= dividend;
                        dsr_q <= divisor;
                        prem  <= 5'h00;
                        cnt   <= 4'd8;
                        zdiv  <= (divisor == 4'd0);
                    end
                end
                CALC: begin
                    prem  <= stp[4:0];
                    dvd_q <= {dvd_q[6:0], stp[5]};
                    cnt   <= cnt - 4'd1;
                    if (last_iter) begin
                        quotient  <= {dvd_q[6:0], stp[5]};
                        remainder <= stp[3:0];
                        dbz       <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    if (zdiv) begin
                        quotient  <= 8'hFF;
                        remainder <= 4'hF;
                        dbz       <= 1'b1;
                        done      <= 1'b1;
                        zdiv      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
